// File: rtl/alu_pkg.sv
// Shared definitions for the operand decode stage: opcode/condition/shift encodings,
// instruction field positions and the opcode source/destination usage decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_AND  = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_MOVI = 4'b0110,
        OP_MOV  = 4'b0111,
        OP_CMP  = 4'b1011,
        OP_LDR  = 4'b1101,
        OP_STR  = 4'b1110
    } opcode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_AL = 4'b1110
    } cond_e;

    typedef enum logic [2:0] {
        SR_NONE = 3'b000,
        SR_RSH  = 3'b001,
        SR_LSH  = 3'b010,
        SR_ROR  = 3'b011
    } sr_cont_e;

    localparam int COND_MSB   = 31;
    localparam int COND_LSB   = 28;
    localparam int OPC_MSB    = 27;
    localparam int OPC_LSB    = 24;
    localparam int S_BIT      = 23;
    localparam int SRC_MSB    = 22;
    localparam int SRC_LSB    = 20;
    localparam int RD_MSB     = 19;
    localparam int RD_LSB     = 16;
    localparam int RN_MSB     = 15;
    localparam int RN_LSB     = 12;
    localparam int RM_MSB     = 11;
    localparam int RM_LSB     = 8;
    localparam int SRB_MSB    = 7;
    localparam int SRB_LSB    = 3;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef struct packed {
        logic legal;
        logic uses_rn;
        logic uses_rm;
        logic writes_rd;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [3:0] op);
        op_info_t info;
        info = '{legal: 1'b0, uses_rn: 1'b0, uses_rm: 1'b0, writes_rd: 1'b0};
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR:
                info = '{legal: 1'b1, uses_rn: 1'b1, uses_rm: 1'b1, writes_rd: 1'b1};
            OP_MOVI:
                info = '{legal: 1'b1, uses_rn: 1'b0, uses_rm: 1'b0, writes_rd: 1'b1};
            OP_MOV, OP_LDR:
                info = '{legal: 1'b1, uses_rn: 1'b1, uses_rm: 1'b0, writes_rd: 1'b1};
            OP_CMP:
                info = '{legal: 1'b1, uses_rn: 1'b1, uses_rm: 1'b1, writes_rd: 1'b0};
            OP_STR:
                info = '{legal: 1'b1, uses_rn: 1'b1, uses_rm: 1'b0, writes_rd: 1'b0};
            default:
                info = '{legal: 1'b0, uses_rn: 1'b0, uses_rm: 1'b0, writes_rd: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/operand_decode_stage_if.sv
// Instruction input, writeback and ALU-facing bundle signals of the operand decode stage.
// master drives instructions/writebacks/out_ready; slave is the decode stage itself.
interface operand_decode_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              wb_en;
    logic [3:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_in1;
    logic [DATA_W-1:0] out_in2;
    logic [3:0]        out_opcode;
    logic [3:0]        out_cond;
    logic              out_s;
    logic [2:0]        out_sr_cont;
    logic [4:0]        out_sr_bit;
    logic [15:0]       out_imm;
    logic [3:0]        out_rd;
    logic              out_we;
    logic              illegal;

    modport master (
        output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_in1, out_in2, out_opcode, out_cond, out_s,
               out_sr_cont, out_sr_bit, out_imm, out_rd, out_we, illegal
    );

    modport slave (
        input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_in1, out_in2, out_opcode, out_cond, out_s,
               out_sr_cont, out_sr_bit, out_imm, out_rd, out_we, illegal
    );
endinterface

// File: rtl/reg_file.sv
// 16-entry architectural register file: two combinational read ports, one write port,
// synchronous reset of every entry to REG_RESET_VAL.
module reg_file #(
    parameter int                DATA_W        = 32,
    parameter logic [DATA_W-1:0] REG_RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] regs_r [16];

    // Register array update: reset fill, otherwise writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= REG_RESET_VAL;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];
endmodule

// File: rtl/operand_decode_stage.sv
// Decode/operand-read stage feeding the ALU, with RAW scoreboard and registered bundle.
// Optional build macro DECODE_BYPASS_EN forwards same-cycle writeback data to the sources.
module operand_decode_stage
    import alu_pkg::*;
#(
    parameter int                DATA_W        = 32,
    parameter logic [DATA_W-1:0] REG_RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    operand_decode_stage_if.slave  bus
);
    logic [3:0]        op_s;
    logic [3:0]        rd_s;
    logic [3:0]        rn_s;
    logic [3:0]        rm_s;
    op_info_t          info_s;
    logic              rn_hit_s;
    logic              rm_hit_s;
    logic              rn_haz_s;
    logic              rm_haz_s;
    logic              stall_s;
    logic              ready_s;
    logic              xfer_s;
    logic              issue_s;
    logic [DATA_W-1:0] rf_a_s;
    logic [DATA_W-1:0] rf_b_s;
    logic [DATA_W-1:0] opnd_a_s;
    logic [DATA_W-1:0] opnd_b_s;
    logic [15:0]       clr_mask_s;
    logic [15:0]       set_mask_s;
    logic [15:0]       pending_r;

    logic              out_valid_r;
    logic              illegal_r;
    logic [DATA_W-1:0] in1_r;
    logic [DATA_W-1:0] in2_r;
    logic [3:0]        opcode_r;
    logic [3:0]        cond_r;
    logic              s_r;
    logic [2:0]        sr_cont_r;
    logic [4:0]        sr_bit_r;
    logic [15:0]       imm_r;
    logic [3:0]        rd_r;
    logic              we_r;

    reg_file #(
        .DATA_W        (DATA_W),
        .REG_RESET_VAL (REG_RESET_VAL)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_en),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (rn_s),
        .raddr_b (rm_s),
        .rdata_a (rf_a_s),
        .rdata_b (rf_b_s)
    );

    // Field extraction and detection of a writeback landing on a source this cycle.
    always_comb begin
        op_s     = bus.in_instr[OPC_MSB:OPC_LSB];
        rd_s     = bus.in_instr[RD_MSB:RD_LSB];
        rn_s     = bus.in_instr[RN_MSB:RN_LSB];
        rm_s     = bus.in_instr[RM_MSB:RM_LSB];
        info_s   = decode_op(op_s);
        rn_hit_s = bus.wb_en && (bus.wb_addr == rn_s);
        rm_hit_s = bus.wb_en && (bus.wb_addr == rm_s);
    end

`ifdef DECODE_BYPASS_EN
    // A source being written this cycle takes wb_data and no longer counts as pending.
    always_comb begin
        rn_haz_s = info_s.uses_rn && pending_r[rn_s] && !rn_hit_s;
        rm_haz_s = info_s.uses_rm && pending_r[rm_s] && !rm_hit_s;
        opnd_a_s = rn_hit_s ? bus.wb_data : rf_a_s;
        opnd_b_s = rm_hit_s ? bus.wb_data : rf_b_s;
    end
`else
    // Without forwarding, a source being written this cycle waits until the array holds it.
    always_comb begin
        rn_haz_s = info_s.uses_rn && (pending_r[rn_s] || rn_hit_s);
        rm_haz_s = info_s.uses_rm && (pending_r[rm_s] || rm_hit_s);
        opnd_a_s = rf_a_s;
        opnd_b_s = rf_b_s;
    end
`endif

    // Handshake: stall on hazards, accept only when the output slot frees up.
    always_comb begin
        stall_s    = bus.in_valid && info_s.legal && (rn_haz_s || rm_haz_s);
        ready_s    = !stall_s && (!out_valid_r || bus.out_ready);
        xfer_s     = bus.in_valid && ready_s;
        issue_s    = xfer_s && info_s.legal;
        clr_mask_s = bus.wb_en ? (16'h0001 << bus.wb_addr) : 16'h0000;
        set_mask_s = (issue_s && info_s.writes_rd) ? (16'h0001 << rd_s) : 16'h0000;
    end

    // Scoreboard: a new destination claim outranks a writeback release to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 16'h0000;
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Output bundle register and illegal-opcode pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            in1_r       <= {DATA_W{1'b0}};
            in2_r       <= {DATA_W{1'b0}};
            opcode_r    <= 4'h0;
            cond_r      <= 4'h0;
            s_r         <= 1'b0;
            sr_cont_r   <= 3'b000;
            sr_bit_r    <= 5'd0;
            imm_r       <= 16'h0000;
            rd_r        <= 4'h0;
            we_r        <= 1'b0;
        end else begin
            illegal_r <= xfer_s && !info_s.legal;
            if (issue_s) begin
                out_valid_r <= 1'b1;
                in1_r       <= info_s.uses_rn ? opnd_a_s : {DATA_W{1'b0}};
                in2_r       <= info_s.uses_rm ? opnd_b_s : {DATA_W{1'b0}};
                opcode_r    <= op_s;
                cond_r      <= bus.in_instr[COND_MSB:COND_LSB];
                s_r         <= bus.in_instr[S_BIT];
                sr_cont_r   <= bus.in_instr[SRC_MSB:SRC_LSB];
                sr_bit_r    <= bus.in_instr[SRB_MSB:SRB_LSB];
                imm_r       <= bus.in_instr[IMM_MSB:IMM_LSB];
                rd_r        <= rd_s;
                we_r        <= info_s.writes_rd;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.illegal     = illegal_r;
    assign bus.out_in1     = in1_r;
    assign bus.out_in2     = in2_r;
    assign bus.out_opcode  = opcode_r;
    assign bus.out_cond    = cond_r;
    assign bus.out_s       = s_r;
    assign bus.out_sr_cont = sr_cont_r;
    assign bus.out_sr_bit  = sr_bit_r;
    assign bus.out_imm     = imm_r;
    assign bus.out_rd      = rd_r;
    assign bus.out_we      = we_r;
endmodule

// File: doc/operand_decode_stage.md
Name: operand_decode_stage

Overview:
- Pipeline stage directly upstream of the ALU: accepts 32-bit instruction words, decodes them into the ALU control fields, reads two source operands from a 16x32 register file, and presents a registered operand/control bundle to the ALU.
- Owns the architectural register file and its writeback port.
- Tracks pending writes with a scoreboard and stalls on read-after-write hazards.

Parameters:
- DATA_W, 32, operand and register width.
- REG_RESET_VAL, 0, value loaded into every register on reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  stage can accept the instruction this cycle.
- in_instr  input  32  instruction word.
- wb_en  input  1  writeback strobe from the ALU result path.
- wb_addr  input  4  writeback register index.
- wb_data  input  DATA_W  writeback value.
- out_valid  output  1  bundle valid toward the ALU.
- out_ready  input  1  ALU consumes the bundle.
- out_in1, out_in2  output  DATA_W  operands Rn and Rm.
- out_opcode  output  4  ALU opcode.
- out_cond  output  4  condition field.
- out_s  output  1  set-flags bit.
- out_sr_cont  output  3  shift/rotate select.
- out_sr_bit  output  5  shift amount.
- out_imm  output  16  immediate.
- out_rd  output  4  destination register.
- out_we  output  1  instruction writes Rd.
- illegal  output  1  one-cycle pulse when an illegal opcode is dropped.

Behaviour:
- Instruction format:
  - [31:28] Cond, [27:24] Opcode, [23] S, [22:20] SR_Cont, [19:16] Rd, [15:12] Rn, [11:8] Rm, [7:3] SR_Bit, [2:0] reserved (ignored).
  - Immediate is [15:0], all opcodes. It is meaningful only for MOVI (0110).
- Legal opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR, 0110 MOVI, 0111 MOV, 1011 CMP, 1101 LDR, 1110 STR.
  - Legal opcodes other than CMP and STR set out_we=1; CMP and STR set out_we=0.
- Illegal opcodes (1000, 1001, 1010, 1100, 1111): accepted when in_ready=1 and dropped without producing an output bundle. illegal pulses high for exactly one cycle (registered), and the scoreboard is unchanged.
- Source usage:
  - MOVI reads no register.
  - MOV, LDR and STR read Rn only.
  - All other legal opcodes read Rn and Rm.
- Output register handshake:
  - in_ready = !stall && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready. On transfer of a legal instruction, the bundle is loaded and out_valid is set next cycle.
  - Bundle is cleared from out_valid when out_valid && out_ready with no new transfer.
  - Bundle is held stable while out_valid && !out_ready.
  - Latency is 1 cycle from accept to out_valid.
- Scoreboard:
  - 16 pending bits, one per register.
  - On transfer with out_we=1, pending[Rd] is set.
  - On wb_en, pending[wb_addr] is cleared.
  - If both hit the same register in the same cycle, set wins.
- Stall: stall=1 when in_valid, the opcode is legal, and any register the opcode reads has its pending bit set. No bundle is produced while stalled.
- Register file:
  - Written on wb_en at the clock edge.
  - Reads are combinational from the current array.
  - Writes to any index are allowed; R0 is not hardwired.
- Reset:
  - out_valid=0, illegal=0, all other outputs 0.
  - Scoreboard cleared; all registers set to REG_RESET_VAL; in_ready=1 in the first cycle after reset.
  - Reset mid-stall or mid-backpressure discards the held bundle.

Optional Feature:
- DECODE_BYPASS_EN defined:
  - A source whose index equals wb_addr while wb_en=1 takes wb_data directly.
  - That source is not considered pending for the stall check in that cycle, so the hazard resolves the same cycle as writeback.
- DECODE_BYPASS_EN undefined:
  - No bypass. The stall additionally asserts when wb_en=1 and wb_addr matches a used source.
  - The operand is read from the array one cycle after writeback, giving one extra stall cycle.

Decomposition:
- Shared package alu_pkg:
  - opcode constants, condition codes, SR_Cont encodings (000 none, 001 right shift, 010 left shift, 011 rotate right);
  - instruction field bit positions;
  - a function that returns uses_rn/uses_rm/writes_rd from an opcode.
- One natural sub-module: reg_file (16 x DATA_W, two combinational read ports, one synchronous write port, synchronous reset).

Test Plan:
- Reset, then `wb_en=1 wb_addr=3 wb_data=5`, `wb_addr=4 wb_data=7`, then ADD Rd=1 Rn=3 Rm=4 -> out_valid next cycle; out_in1=5, out_in2=7, out_opcode=0000, out_we=1, out_rd=1.
- ADD Rd=2 followed back-to-back by SUB Rn=2 -> SUB stalled (in_ready=0) until `wb_en wb_addr=2 wb_data=9`; SUB is then issued with out_in1=9.
  - With DECODE_BYPASS_EN, issue occurs in the writeback cycle.
  - Without it, issue occurs one cycle later.
- out_ready=0 for 3 cycles with out_valid=1 -> bundle stable, in_ready=0; next instruction accepted the cycle out_ready returns to 1.
- Opcode 1111 presented -> in_ready=1, illegal pulses once, out_valid stays 0, no pending bit set.
- MOVI Rd=5 imm=16'hBEEF while pending[5] is set from an earlier op -> no stall (MOVI reads nothing); out_imm=16'hBEEF; pending[5] stays set.
- rst asserted while a stalled SUB and a held bundle exist -> next cycle out_valid=0, scoreboard clear, register 3 reads REG_RESET_VAL.
